// File: rtl/tc_count_sequencer_if.sv
// tc_count_sequencer_if: bundle between the sequencer, its 8-bit counter
// and the controlling logic.
//
// Handshake: start is a request sampled only while busy is low. An accepted
// start (start & !stop & start_val < limit) raises busy in the next cycle.
// A rejected start (start_val >= limit) pulses err in the next cycle instead.
// start is ignored while busy is high. stop aborts a busy sequence and wins
// over start and over a terminal hit.
interface tc_count_sequencer_if #(
  parameter int BIT_WIDTH = 8,
  parameter int RUN_W     = 8
);
  logic                 start;
  logic                 stop;
  logic [BIT_WIDTH-1:0] start_val;
  logic [BIT_WIDTH-1:0] limit;
  logic [RUN_W-1:0]     runs;
  logic [BIT_WIDTH-1:0] cnt_in;
  logic                 cnt_rst;
  logic                 cnt_save;
  logic [BIT_WIDTH-1:0] cnt_load;
  logic                 busy;
  logic                 tick;
  logic                 done;
  logic                 err;
  logic [RUN_W-1:0]     wraps;

  modport master (
    output start, stop, start_val, limit, runs, cnt_in,
    input  cnt_rst, cnt_save, cnt_load, busy, tick, done, err, wraps
  );

  modport slave (
    input  start, stop, start_val, limit, runs, cnt_in,
    output cnt_rst, cnt_save, cnt_load, busy, tick, done, err, wraps
  );
endinterface

// File: rtl/tc_count_sequencer.sv
// tc_count_sequencer: control stage wrapped around an 8-bit counter. Watches
// the counter value for a terminal value, reloads a start value and emits a
// tick per period, forever (runs == 0) or for a fixed number of periods.
// Optional feature macro: TC_SEQ_WRAPCNT_EN (exposes the per-sequence hit
// count on wraps; otherwise wraps is tied to zero).
module tc_count_sequencer #(
  parameter int UUID      = 0,
  parameter     NAME      = "",
  parameter int BIT_WIDTH = 8,
  parameter int RUN_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  tc_count_sequencer_if.slave  bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [BIT_WIDTH-1:0] sv_q, lim_q;
  logic [RUN_W-1:0]     runs_q, run_cnt;
  logic                 tick_q, done_q, err_q;
  logic                 tick_nx, done_nx, err_nx;
  logic                 latch, run_inc, cnt_save_c;
  logic                 hit, last;

  // >= rather than == so a counter stepping past the limit still hits.
  assign hit  = (bus.cnt_in >= lim_q);
  assign last = (runs_q != '0) && (run_cnt == runs_q - RUN_W'(1));

  // Next-state and Moore/Mealy decode; stop outranks hit and start.
  always_comb begin
    state_nx   = state;
    latch      = 1'b0;
    run_inc    = 1'b0;
    cnt_save_c = 1'b0;
    tick_nx    = 1'b0;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.start_val >= bus.limit) begin
            err_nx = 1'b1;
          end else if (!bus.stop) begin
            latch    = 1'b1;
            state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (bus.stop) begin
          state_nx = S_IDLE;
        end else begin
          cnt_save_c = 1'b1;
          state_nx   = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_nx = S_IDLE;
        end else if (hit) begin
          tick_nx = 1'b1;
          run_inc = 1'b1;
          if (last) begin
            done_nx  = 1'b1;
            state_nx = S_IDLE;
          end else begin
            cnt_save_c = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, latched operands, period counter and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sv_q    <= '0;
      lim_q   <= '0;
      runs_q  <= '0;
      run_cnt <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      tick_q <= tick_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      if (latch) begin
        sv_q    <= bus.start_val;
        lim_q   <= bus.limit;
        runs_q  <= bus.runs;
        run_cnt <= '0;
      end else if (run_inc) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

`ifdef TC_SEQ_WRAPCNT_EN
  logic [RUN_W-1:0] wraps_q;

  // Hit counter: cleared by an accepted start, held through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wraps_q <= '0;
    end else if (latch) begin
      wraps_q <= '0;
    end else if (run_inc) begin
      wraps_q <= wraps_q + RUN_W'(1);
    end
  end

  assign bus.wraps = wraps_q;
`else
  assign bus.wraps = '0;
`endif

  // The counter is held in reset whenever no sequence is active.
  assign bus.cnt_rst  = (state == S_IDLE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.cnt_save = cnt_save_c;
  assign bus.cnt_load = sv_q;
  assign bus.tick     = tick_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_tc_count_sequencer.sv
// tb_tc_count_sequencer: directed bench with an 8-bit counter model and a
// schedule-based reference (hit cycles derived arithmetically from start
// cycle, start value, limit and counter step).
module tb_tc_count_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc;
  int         step;
  int         n_vec;
  int         n_err;

  tc_count_sequencer_if #(.BIT_WIDTH(8), .RUN_W(8)) bus ();

  tc_count_sequencer #(.BIT_WIDTH(8), .RUN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter being controlled: reset wins over save, else count by step.
  always @(posedge clk) begin
    if (rst || bus.cnt_rst) bus.cnt_in <= 8'd0;
    else if (bus.cnt_save)  bus.cnt_in <= bus.cnt_load;
    else                    bus.cnt_in <= bus.cnt_in + 8'(step);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + compare ----------------
  bit seq_on, p_tick, p_done, p_err;
  int seq_t, seq_k, seq_n, m_wraps, m_load;

  always @(negedge clk) begin
    bit busy_e, hit, last, save_e;
    int p, exp_w;
    if (rst) begin
      seq_on = 0; p_tick = 0; p_done = 0; p_err = 0;
      m_wraps = 0; m_load = 0;
    end else begin
`ifdef TC_SEQ_WRAPCNT_EN
      exp_w = m_wraps;
`else
      exp_w = 0;
`endif
      chk("m_tick", int'(bus.tick), int'(p_tick));
      chk("m_done", int'(bus.done), int'(p_done));
      chk("m_err", int'(bus.err), int'(p_err));
      chk("m_wraps", int'(bus.wraps), exp_w);
      chk("m_load", int'(bus.cnt_load), m_load);
      busy_e = seq_on && (cyc > seq_t);
      hit = 0; last = 0;
      if (busy_e && cyc >= seq_t + 2 + seq_k &&
          ((cyc - seq_t - 2 - seq_k) % (seq_k + 1)) == 0) begin
        hit  = 1;
        p    = (cyc - seq_t - 2 - seq_k) / (seq_k + 1);
        last = (seq_n != 0) && (p == seq_n - 1);
      end
      save_e = busy_e && !bus.stop && (cyc == seq_t + 1 || (hit && !last));
      chk("m_busy", int'(bus.busy), int'(busy_e));
      chk("m_cnt_rst", int'(bus.cnt_rst), int'(!busy_e));
      chk("m_cnt_save", int'(bus.cnt_save), int'(save_e));
      p_tick = hit && !bus.stop;
      p_done = p_tick && last;
      if (p_tick) m_wraps = (m_wraps + 1) % 256;
      if (busy_e && (bus.stop || p_done)) seq_on = 0;
      p_err = !busy_e && bus.start && (bus.start_val >= bus.limit);
      if (!busy_e && bus.start && !bus.stop && bus.start_val < bus.limit) begin
        seq_on  = 1;
        seq_t   = cyc;
        seq_k   = (int'(bus.limit) - int'(bus.start_val) + step - 1) / step;
        seq_n   = int'(bus.runs);
        m_wraps = 0;
        m_load  = int'(bus.start_val);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int sv, input int lim, input int rn);
    bus.start_val = 8'(sv);
    bus.limit     = 8'(lim);
    bus.runs      = 8'(rn);
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] a_seq [5];
  int         ticks;
  int         exp_w3;

  initial begin
    a_seq = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd3};
    cyc = 0; n_vec = 0; n_err = 0; step = 1;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0;
    set_op(0, 0, 0);
`ifdef TC_SEQ_WRAPCNT_EN
    exp_w3 = 3;
`else
    exp_w3 = 0;
`endif
    repeat (3) next_cycle();
    rst = 1'b0;

    // Idle after reset: counter held, nothing pulses.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_cnt_rst", int'(bus.cnt_rst), 1);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_save", int'(bus.cnt_save), 0);
      chk("idle_pulses", int'({bus.tick, bus.done, bus.err}), 0);
      chk("idle_load", int'(bus.cnt_load), 0);
      next_cycle();
    end

    // Free-running: 3..6, step 1, start during RUN ignored, stop on a hit.
    set_op(3, 6, 0); bus.start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 6) chk("a_cnt_in", int'(bus.cnt_in), int'(a_seq[i-2]));
      if (i == 6 || i == 10) chk("a_tick_hi", int'(bus.tick), 1);
      if (i == 7) chk("a_tick_lo", int'(bus.tick), 0);
      if (i == 13) begin
        chk("a_stop_cnt", int'(bus.cnt_in), 6);
        chk("a_stop_save", int'(bus.cnt_save), 0);
      end
      next_cycle();
      bus.start = (i == 7);
      bus.stop  = (i == 12);
    end
    bus.stop = 1'b0;
    @(negedge clk);
    chk("a_stop_tick", int'(bus.tick), 0);
    chk("a_stop_busy", int'(bus.busy), 0);
    next_cycle();

    // Finite run of 3 periods, then restart in the same cycle as done.
    set_op(0, 2, 3); bus.start = 1'b1;
    ticks = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i <= 11 && bus.tick) ticks++;
      if (i == 11) begin
        chk("b_done", int'(bus.done), 1);
        chk("b_busy_end", int'(bus.busy), 0);
        chk("b_cnt_rst", int'(bus.cnt_rst), 1);
        chk("b_ticks", ticks, 3);
        chk("b_wraps", int'(bus.wraps), exp_w3);
      end
      if (i == 12) chk("b_reload", int'(bus.cnt_save), 1);
      if (i == 16) chk("b_done2", int'(bus.done), 1);
      next_cycle();
      bus.start = (i == 10);
      if (i == 10) set_op(0, 2, 1);
    end
    bus.start = 1'b0;

    // Rejected start: start_val == limit.
    set_op(9, 9, 0); bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    @(negedge clk);
    chk("c_err", int'(bus.err), 1);
    chk("c_busy", int'(bus.busy), 0);
    next_cycle();
    @(negedge clk);
    chk("c_err_pulse", int'(bus.err), 0);
    next_cycle();

    // Counter step 2 overshoots the limit: 1,3,5,7 -> hit at 7.
    step = 2;
    set_op(1, 6, 2); bus.start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("d_hit_cnt", int'(bus.cnt_in), 7);
        chk("d_hit_save", int'(bus.cnt_save), 1);
      end
      if (i == 6) begin
        chk("d_tick", int'(bus.tick), 1);
        chk("d_reload", int'(bus.cnt_in), 1);
      end
      if (i == 10) chk("d_done", int'(bus.done), 1);
      next_cycle();
      bus.start = 1'b0;
    end
    step = 1;

    // Stop during LOAD suppresses the reload.
    set_op(0, 4, 0); bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0; bus.stop = 1'b1;
    @(negedge clk);
    chk("e_load_save", int'(bus.cnt_save), 0);
    next_cycle();
    bus.stop = 1'b0;
    @(negedge clk);
    chk("e_load_busy", int'(bus.busy), 0);
    next_cycle();

    // Reset in the middle of an infinite sequence.
    bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      bus.start = 1'b0;
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("f_busy", int'(bus.busy), 0);
      chk("f_done", int'(bus.done), 0);
      chk("f_wraps", int'(bus.wraps), 0);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
